// File: rtl/lsu_rmw_pkg.sv
// Shared constants for the load/store unit: funct3 encodings, FSM state
// encodings and small decode helpers used by both the datapath and the FSM.
package lsu_rmw_pkg;

  localparam int DATA_W = 32;

  // Load/store width encodings as they arrive in Funct3M
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Read-modify-write sequencer states
  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_RD   = 2'd1;
  localparam logic [1:0] LSU_WR   = 2'd2;

  // Byte access (signed or unsigned)
  function automatic logic isByte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  // Halfword access (signed or unsigned); every other encoding is a word
  function automatic logic isHalf(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Data memory bus between the load/store unit (master) and the word-only
// data memory (slave). Read data is combinational from the address.
interface lsu_rmw_if #(parameter int ADDR_W = 8);
  import lsu_rmw_pkg::*;

  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemWE;
  logic [DATA_W-1:0] MemRData;

  modport master (output MemAddr, output MemWData, output MemWE, input MemRData);
  modport slave  (input MemAddr, input MemWData, input MemWE, output MemRData);

endinterface

// File: rtl/lsu_rmw_lane.sv
// Byte-lane datapath. With merge_i=0 it extracts and extends a load result
// from word_i; with merge_i=1 it replaces the addressed lane of word_i with
// the store data. Words pass through unchanged in both modes.
module lsu_lane
  import lsu_rmw_pkg::*;
(
  input  logic        merge_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] word_i,
  input  logic [15:0] data_i,
  output logic [31:0] result_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic        signExt;

  // Lane select, then either extend (load) or splice in store data (merge)
  always_comb begin
    byteSel  = word_i[{lane_i, 3'b000} +: 8];
    halfSel  = lane_i[1] ? word_i[31:16] : word_i[15:0];
    signExt  = ~funct3_i[2];
    result_o = word_i;
    if (merge_i) begin
      if (isByte(funct3_i)) begin
        result_o[{lane_i, 3'b000} +: 8] = data_i[7:0];
      end else if (isHalf(funct3_i)) begin
        if (lane_i[1]) result_o[31:16] = data_i;
        else           result_o[15:0]  = data_i;
      end
    end else begin
      if (isByte(funct3_i)) begin
        result_o = {{24{signExt & byteSel[7]}}, byteSel};
      end else if (isHalf(funct3_i)) begin
        result_o = {{16{signExt & halfSel[15]}}, halfSel};
      end
    end
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit between EX/MEM and a word-only data memory. Word stores
// go straight through; byte/half stores run a read-modify-write sequence
// (IDLE -> RD -> WR) that stalls the pipeline for two cycles. Loads are
// combinational. Misaligned word/half accesses are dropped and flagged.
module lsu_rmw
  import lsu_rmw_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  Funct3M,
  lsu_rmw_if.master   dmem,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       old_q, old_d;

  logic        idle, inRd, inWr;
  logic        misalign, storeWord, storeSub, loadOk;
  logic [31:0] loadExt, merged;
  logic        unused_addrHi;

  assign unused_addrHi = ^ALUResultM[31:ADDR_W+2];

  assign idle = (state_q == LSU_IDLE);
  assign inRd = (state_q == LSU_RD);
  assign inWr = (state_q == LSU_WR);

  // Decode the incoming request; only meaningful while idle
  always_comb begin
    if (isByte(Funct3M))      misalign = 1'b0;
    else if (isHalf(Funct3M)) misalign = ALUResultM[0];
    else                      misalign = (ALUResultM[1:0] != 2'b00);
    storeWord = idle && MemWriteM && !misalign && !isByte(Funct3M) && !isHalf(Funct3M);
    storeSub  = idle && MemWriteM && !misalign && (isByte(Funct3M) || isHalf(Funct3M));
    loadOk    = idle && MemReadM && !MemWriteM && !misalign;
  end

  // Sequencer next state and capture of the store operands / old word
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    f3_d    = f3_q;
    old_d   = old_q;
    case (state_q)
      LSU_IDLE: begin
        if (storeSub) begin
          state_d = LSU_RD;
          addr_d  = ALUResultM[ADDR_W+1:0];
          data_d  = WriteDataM[15:0];
          f3_d    = Funct3M;
        end
      end
      LSU_RD: begin
        old_d   = dmem.MemRData;
        state_d = LSU_WR;
      end
      LSU_WR:  state_d = LSU_IDLE;
      default: state_d = LSU_IDLE;
    endcase
  end

  // State and capture registers; reset also aborts an in-flight store
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      f3_q    <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      f3_q    <= f3_d;
      old_q   <= old_d;
    end
  end

  lsu_lane u_loadLane (
    .merge_i  (1'b0),
    .lane_i   (ALUResultM[1:0]),
    .funct3_i (Funct3M),
    .word_i   (dmem.MemRData),
    .data_i   (WriteDataM[15:0]),
    .result_o (loadExt)
  );

  lsu_lane u_mergeLane (
    .merge_i  (1'b1),
    .lane_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .word_i   (old_q),
    .data_i   (data_q),
    .result_o (merged)
  );

  // Bus and pipeline outputs; everything is quiet while reset is held
  always_comb begin
    dmem.MemAddr  = idle ? ALUResultM[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
    dmem.MemWData = inWr ? merged : WriteDataM;
    dmem.MemWE    = rst && (storeWord || inWr);
    ReadDataM     = (rst && loadOk) ? loadExt : 32'h0;
    StallM        = rst && (storeSub || inRd);
    MisalignM     = rst && idle && (MemWriteM || MemReadM) && misalign;
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw. Each driven cycle pushes its expected
// outputs onto a scoreboard queue; a monitor pops and compares them a short
// time after the inputs settle. Memory contents are checked from the
// bench's own behavioural memory.
module tb_lsu_rmw;
  import lsu_rmw_pkg::*;

  typedef struct {
    string       tag;
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        stall;
    logic        mis;
  } expCycle_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        MemWriteM, MemReadM, StallM, MisalignM;
  logic [2:0]  Funct3M;
  logic [31:0] mem [256] = '{default: 32'h0};

  expCycle_t expQ[$];
  expCycle_t monE;
  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  lsu_rmw_if #(.ADDR_W(8)) bus ();

  lsu_rmw #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .Funct3M    (Funct3M),
    .dmem       (bus),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM)
  );

  always #5 clk = ~clk;

  // Behavioural 256x32 data memory: combinational read, posedge write
  assign bus.MemRData = mem[bus.MemAddr];
  always @(posedge clk) begin
    if (bus.MemWE) mem[bus.MemAddr] <= bus.MemWData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the DUT must show
  task automatic applyStimulus(input string tag, input logic r, input logic we,
                               input logic re, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [7:0] eAddr, input logic eWe,
                               input logic [31:0] eWData, input logic [31:0] eRd,
                               input logic eStall, input logic eMis);
    expCycle_t e;
    @(negedge clk);
    rst        = r;
    MemWriteM  = we;
    MemReadM   = re;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wdata;
    e.tag   = tag;
    e.addr  = eAddr;
    e.we    = eWe;
    e.wdata = eWData;
    e.rd    = eRd;
    e.stall = eStall;
    e.mis   = eMis;
    expQ.push_back(e);
  endtask

  // Scoreboard consumer: compares each queued cycle once outputs have settled
  always @(negedge clk) begin
    #2;
    if (expQ.size() != 0) begin
      monE = expQ.pop_front();
      checkOutput({monE.tag, "/MemAddr"}, 32'(bus.MemAddr), 32'(monE.addr));
      checkOutput({monE.tag, "/MemWE"}, 32'(bus.MemWE), 32'(monE.we));
      checkOutput({monE.tag, "/ReadDataM"}, ReadDataM, monE.rd);
      checkOutput({monE.tag, "/StallM"}, 32'(StallM), 32'(monE.stall));
      checkOutput({monE.tag, "/MisalignM"}, 32'(MisalignM), 32'(monE.mis));
      if (monE.we) checkOutput({monE.tag, "/MemWData"}, bus.MemWData, monE.wdata);
    end
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0; Funct3M = F3_W;
    ALUResultM = '0; WriteDataM = '0;

    // Reset held with a store request: nothing may happen
    applyStimulus("rst0a", 0, 1, 0, F3_W, 32'h0, 32'h12345678, 8'd0, 0, 32'h0, 32'h0, 0, 0);
    applyStimulus("rst0b", 0, 1, 0, F3_W, 32'h0, 32'h12345678, 8'd0, 0, 32'h0, 32'h0, 0, 0);
    applyStimulus("idle0", 1, 0, 0, F3_W, 32'h0, 32'h0, 8'd0, 0, 32'h0, 32'h0, 0, 0);
    checkOutput("mem0 after reset", mem[0], 32'h0);

    // Word store then word load
    applyStimulus("sw10", 1, 1, 0, F3_W, 32'h10, 32'hDEADBEEF, 8'd4, 1, 32'hDEADBEEF, 32'h0, 0, 0);
    applyStimulus("lw10", 1, 0, 1, F3_W, 32'h10, 32'h0, 8'd4, 0, 32'h0, 32'hDEADBEEF, 0, 0);

    // Byte store into lane 2 with junk inputs during RD/WR
    applyStimulus("sw10b", 1, 1, 0, F3_W, 32'h10, 32'h11223344, 8'd4, 1, 32'h11223344, 32'h0, 0, 0);
    applyStimulus("sb12", 1, 1, 0, F3_B, 32'h12, 32'h000000AB, 8'd4, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus("sb12rd", 1, 1, 0, F3_W, 32'h40, 32'hFFFFFFFF, 8'd4, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus("sb12wr", 1, 0, 1, F3_H, 32'h41, 32'h0, 8'd4, 1, 32'h11AB3344, 32'h0, 0, 0);
    applyStimulus("lbu12", 1, 0, 1, F3_BU, 32'h12, 32'h0, 8'd4, 0, 32'h0, 32'h000000AB, 0, 0);
    checkOutput("mem4 after sb", mem[4], 32'h11AB3344);
    applyStimulus("lb12", 1, 0, 1, F3_B, 32'h12, 32'h0, 8'd4, 0, 32'h0, 32'hFFFFFFAB, 0, 0);
    applyStimulus("lhu12", 1, 0, 1, F3_HU, 32'h12, 32'h0, 8'd4, 0, 32'h0, 32'h000011AB, 0, 0);

    // Half store into the upper half of an empty word
    applyStimulus("sh16", 1, 1, 0, F3_H, 32'h16, 32'h00008001, 8'd5, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus("sh16rd", 1, 1, 0, F3_H, 32'h16, 32'h00008001, 8'd5, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus("sh16wr", 1, 1, 0, F3_H, 32'h16, 32'h00008001, 8'd5, 1, 32'h80010000, 32'h0, 0, 0);
    applyStimulus("lh16", 1, 0, 1, F3_H, 32'h16, 32'h0, 8'd5, 0, 32'h0, 32'hFFFF8001, 0, 0);
    checkOutput("mem5 after sh", mem[5], 32'h80010000);
    applyStimulus("lhu16", 1, 0, 1, F3_HU, 32'h16, 32'h0, 8'd5, 0, 32'h0, 32'h00008001, 0, 0);

    // Misalignment, byte at odd address, funct3 011 as word, write/read conflict
    applyStimulus("sw11mis", 1, 1, 0, F3_W, 32'h11, 32'hFFFFFFFF, 8'd4, 0, 32'h0, 32'h0, 0, 1);
    applyStimulus("lh13mis", 1, 0, 1, F3_H, 32'h13, 32'h0, 8'd4, 0, 32'h0, 32'h0, 0, 1);
    applyStimulus("lb13", 1, 0, 1, F3_B, 32'h13, 32'h0, 8'd4, 0, 32'h0, 32'h00000011, 0, 0);
    applyStimulus("sw1c_f3_3", 1, 1, 0, 3'b011, 32'h1C, 32'h01020304, 8'd7, 1, 32'h01020304, 32'h0, 0, 0);
    applyStimulus("wr_rd_18", 1, 1, 1, F3_W, 32'h18, 32'hCAFEF00D, 8'd6, 1, 32'hCAFEF00D, 32'h0, 0, 0);
    applyStimulus("idle1", 1, 0, 0, F3_W, 32'h0, 32'h0, 8'd0, 0, 32'h0, 32'h0, 0, 0);
    checkOutput("mem4 untouched", mem[4], 32'h11AB3344);
    checkOutput("mem7 f3=011", mem[7], 32'h01020304);
    checkOutput("mem6 conflict", mem[6], 32'hCAFEF00D);

    // Reset during RD aborts the byte store
    applyStimulus("sb20", 1, 1, 0, F3_B, 32'h20, 32'h00000077, 8'd8, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus("sb20rst", 0, 1, 0, F3_B, 32'h20, 32'h00000077, 8'd8, 0, 32'h0, 32'h0, 0, 0);
    applyStimulus("afterRst", 1, 0, 0, F3_B, 32'h20, 32'h0, 8'd8, 0, 32'h0, 32'h0, 0, 0);
    applyStimulus("idle2", 1, 0, 0, F3_W, 32'h0, 32'h0, 8'd0, 0, 32'h0, 32'h0, 0, 0);
    checkOutput("mem8 after abort", mem[8], 32'h0);

    // Back-to-back byte stores into the same word
    applyStimulus("sb20a", 1, 1, 0, F3_B, 32'h20, 32'h0000005A, 8'd8, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus("sb20a_rd", 1, 1, 0, F3_B, 32'h20, 32'h0000005A, 8'd8, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus("sb20a_wr", 1, 1, 0, F3_B, 32'h20, 32'h0000005A, 8'd8, 1, 32'h0000005A, 32'h0, 0, 0);
    applyStimulus("sb21", 1, 1, 0, F3_B, 32'h21, 32'h000000C3, 8'd8, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus("sb21_rd", 1, 1, 0, F3_B, 32'h21, 32'h000000C3, 8'd8, 0, 32'h0, 32'h0, 1, 0);
    applyStimulus("sb21_wr", 1, 1, 0, F3_B, 32'h21, 32'h000000C3, 8'd8, 1, 32'h0000C35A, 32'h0, 0, 0);
    applyStimulus("idle3", 1, 0, 0, F3_W, 32'h0, 32'h0, 8'd0, 0, 32'h0, 32'h0, 0, 0);
    checkOutput("mem8 merged", mem[8], 32'h0000C35A);

    @(negedge clk);
    #3;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
